// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared MIPS multi-cycle definitions: opcode constants, controller state
// encoding, ALU / PC mux select codes and the wait-counter width.
package multi_cycle_ctrl_pkg;

  // Instruction opcodes (Ins[31:26])
  localparam logic [5:0] OP_R_FORM = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;

  // Memory wait counter width
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    WB_R,
    EXEC_I,
    WB_I,
    BRANCH,
    JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

  // True for every opcode the controller can execute
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_R_FORM, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_BEQ, OP_J: is_legal_op = 1'b1;
      default:                                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on MemReady in a memory state.
// The count is cleared whenever the controller is not waiting, when the access
// completes, or when it aborts, so every wait state is entered with count 0.
//   CLK, RST      clock, async active-low reset
//   waiting       controller is in FETCH / MEM_RD / MEM_WR
//   MemReady      memory handshake
//   timeout       abort this cycle: count reached TMO_CYC and memory not ready
module mem_wait_timer
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic waiting,
  input  logic MemReady,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] cnt;

  // MemReady always wins, so a count equal to TMO_CYC still completes normally
  assign timeout = waiting && !MemReady && (cnt == WAIT_CNT_W'(TMO_CYC));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (waiting && !MemReady && !timeout) begin
      cnt <= cnt + WAIT_CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM of a multi-cycle MIPS subset
// (lw, sw, R-form, addi, ori, beq, j).
//   CLK, RST       clock (rising edge), async active-low reset
//   Op, Funct      instruction fields from the IR
//   Zero           ALU zero flag (consumed by the datapath via PCWriteCond)
//   MemReady       memory handshake
//   PCWrite .. ALUSrcA, ALUSrcB, ALUOp, PCSource   datapath strobes / selects
//   Done           one-cycle pulse in the retiring cycle of an instruction
//   Err            one-cycle pulse on illegal opcode or memory timeout
// Strobes are decoded from the registered state. Handshake-qualified pulses
// (IRWrite/PCWrite in FETCH, Done in MEM_WR, Err) are additionally gated by the
// current MemReady/Op so they land in the completing cycle, and RST forces every
// output low immediately.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Done,
  output logic       Err
);

  state_t state;
  logic   waiting;
  logic   timeout;

  // Funct reaches the ALU control unit and Zero the PC-write gate directly
  logic unused_dp_inputs;
  assign unused_dp_inputs = ^{Funct, Zero};

  assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mem_wait_timer #(
    .TMO_CYC(TMO_CYC)
  ) u_wait (
    .CLK     (CLK),
    .RST     (RST),
    .waiting (waiting),
    .MemReady(MemReady),
    .timeout (timeout)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_R_FORM:      state <= EXEC_R;
            OP_LW, OP_SW:   state <= MEM_ADDR;
            OP_ADDI, OP_ORI: state <= EXEC_I;
            OP_BEQ:         state <= BRANCH;
            OP_J:           state <= JUMP;
            default:        state <= FETCH;
          endcase
        end
        MEM_ADDR: state <= (Op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (MemReady)     state <= MEM_WB;
          else if (timeout) state <= FETCH;
        end
        MEM_WR:   if (MemReady || timeout) state <= FETCH;
        EXEC_R:   state <= WB_R;
        EXEC_I:   state <= WB_I;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    Done        = 1'b0;
    Err         = 1'b0;
    if (RST) begin
      case (state)
        FETCH: begin
          if (timeout) begin
            Err = 1'b1;
          end else begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCWrite = MemReady;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_IMM_SH2;
          Err     = !is_legal_op(Op);
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEM_RD: begin
          if (timeout) begin
            Err = 1'b1;
          end else begin
            MemRead = 1'b1;
            IorD    = 1'b1;
          end
        end
        MEM_WR: begin
          if (timeout) begin
            Err = 1'b1;
          end else begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            Done     = MemReady;
          end
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          Done     = 1'b1;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        WB_R: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          Done     = 1'b1;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = (Op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        end
        WB_I: begin
          RegWrite = 1'b1;
          Done     = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          Done        = 1'b1;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          Done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl. Outputs are packed as
// {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,
//  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],Done,Err}.
// dut uses the default timeout, dut_t uses TMO_CYC=4.
module tb_multi_cycle_ctrl;

  logic       CLK;
  logic       RST;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  wire [17:0] outs;
  wire [17:0] outs_t;

  int unsigned checks;
  int unsigned failures;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RF   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ILL  = 6'b111111;

  //                                    PW PC ID MR MW IR RW RD MR AS SB AO PS D E
  localparam logic [17:0] X_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] X_FETCH    = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] X_FWAIT    = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] X_DEC      = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] X_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] X_MADDR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] X_MRD      = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] X_MWB      = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] X_MWR_WAIT = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] X_MWR_DONE = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] X_EXR      = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] X_WBR      = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] X_EXI_ADD  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] X_EXI_OR   = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
  localparam logic [17:0] X_WBI      = 18'b0_0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  localparam logic [17:0] X_BR       = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] X_JMP      = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] X_ERR      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(outs[17]), .PCWriteCond(outs[16]), .IorD(outs[15]), .MemRead(outs[14]),
    .MemWrite(outs[13]), .IRWrite(outs[12]), .RegWrite(outs[11]), .RegDst(outs[10]),
    .MemtoReg(outs[9]), .ALUSrcA(outs[8]), .ALUSrcB(outs[7:6]), .ALUOp(outs[5:4]),
    .PCSource(outs[3:2]), .Done(outs[1]), .Err(outs[0])
  );

  multi_cycle_ctrl #(.TMO_CYC(4)) dut_t (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(outs_t[17]), .PCWriteCond(outs_t[16]), .IorD(outs_t[15]), .MemRead(outs_t[14]),
    .MemWrite(outs_t[13]), .IRWrite(outs_t[12]), .RegWrite(outs_t[11]), .RegDst(outs_t[10]),
    .MemtoReg(outs_t[9]), .ALUSrcA(outs_t[8]), .ALUSrcB(outs_t[7:6]), .ALUOp(outs_t[5:4]),
    .PCSource(outs_t[3:2]), .Done(outs_t[1]), .Err(outs_t[0])
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Check one cycle mid-period, then advance just past the next rising edge
  task automatic cyc(input string tag, input bit use_t, input logic [17:0] exp);
    @(negedge CLK);
    chk(tag, use_t ? outs_t : outs, exp);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b0;
    Op       = LW;
    Funct    = 6'h20;
    Zero     = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("reset_outs", outs, X_ZERO);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;

    // lw, MemReady always 1: 5 cycles
    cyc("lw_fetch", 0, X_FETCH);
    cyc("lw_dec",   0, X_DEC);
    cyc("lw_addr",  0, X_MADDR);
    cyc("lw_rd",    0, X_MRD);
    cyc("lw_wb",    0, X_MWB);

    // beq taken and not taken: identical strobes
    Op = BEQ; Zero = 1'b1;
    cyc("beq1_fetch", 0, X_FETCH);
    cyc("beq1_dec",   0, X_DEC);
    cyc("beq1_br",    0, X_BR);
    Zero = 1'b0;
    cyc("beq0_fetch", 0, X_FETCH);
    cyc("beq0_dec",   0, X_DEC);
    cyc("beq0_br",    0, X_BR);

    // illegal opcode: Err leaving DECODE, then fresh fetch
    Op = ILL;
    cyc("ill_fetch", 0, X_FETCH);
    cyc("ill_dec",   0, X_DEC_ILL);
    Op = RF; Funct = 6'h22;
    cyc("ill_next_fetch", 0, X_FETCH);
    cyc("r_dec",  0, X_DEC);
    cyc("r_exec", 0, X_EXR);
    cyc("r_wb",   0, X_WBR);

    // addi / ori
    Op = ADDI;
    cyc("addi_fetch", 0, X_FETCH);
    cyc("addi_dec",   0, X_DEC);
    cyc("addi_exec",  0, X_EXI_ADD);
    cyc("addi_wb",    0, X_WBI);
    Op = ORI;
    cyc("ori_fetch", 0, X_FETCH);
    cyc("ori_dec",   0, X_DEC);
    cyc("ori_exec",  0, X_EXI_OR);
    cyc("ori_wb",    0, X_WBI);

    // j
    Op = JMP;
    cyc("j_fetch", 0, X_FETCH);
    cyc("j_dec",   0, X_DEC);
    cyc("j_jump",  0, X_JMP);

    // sw with MemReady low 10 cycles: MemWrite held 11 cycles, Done once
    Op = SW;
    cyc("sw_fetch", 0, X_FETCH);
    cyc("sw_dec",   0, X_DEC);
    cyc("sw_addr",  0, X_MADDR);
    MemReady = 1'b0;
    for (int unsigned i = 0; i < 10; i++) cyc("sw_wait", 0, X_MWR_WAIT);
    MemReady = 1'b1;
    cyc("sw_done", 0, X_MWR_DONE);

    // fetch stall, then R-form interrupted by reset in WB_R
    Op = RF; MemReady = 1'b0;
    cyc("fetch_wait0", 0, X_FWAIT);
    cyc("fetch_wait1", 0, X_FWAIT);
    MemReady = 1'b1;
    cyc("r2_fetch", 0, X_FETCH);
    cyc("r2_dec",   0, X_DEC);
    cyc("r2_exec",  0, X_EXR);
    RST = 1'b0;
    #1;
    chk("rst_async", outs, X_ZERO);
    @(negedge CLK);
    chk("rst_hold", outs, X_ZERO);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    Op  = SW;
    cyc("post_rst_fetch", 0, X_FETCH);

    // TMO_CYC=4 instance: sw times out after 4 wait cycles
    cyc("t_dec",  1, X_DEC);
    cyc("t_addr", 1, X_MADDR);
    MemReady = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cyc("t_wait", 1, X_MWR_WAIT);
    cyc("t_timeout", 1, X_ERR);
    cyc("t_fetch_wait", 1, X_FWAIT);
    MemReady = 1'b1;
    // ready exactly at count == TMO_CYC completes normally
    cyc("t2_fetch", 1, X_FETCH);
    cyc("t2_dec",   1, X_DEC);
    cyc("t2_addr",  1, X_MADDR);
    MemReady = 1'b0;
    for (int unsigned i = 0; i < 4; i++) cyc("t2_wait", 1, X_MWR_WAIT);
    MemReady = 1'b1;
    cyc("t2_done",  1, X_MWR_DONE);
    cyc("t2_next",  1, X_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
